lpf_iq_ctrl: RTL

- Sequencer for the two 43-tap Costas-loop low-pass filters (I arm and Q arm).
- Accepts mixer I/Q samples over a valid/ready handshake and drives the shared filter push strobe and sample data.
- Captures filter results, suppresses outputs until the delay lines hold real data, then decimates and scales/saturates the results for the phase detector.
- Also runs a flush sequence that zeroes both filter delay lines without resetting them.

---
 rtl/lpf_iq_ctrl_if.sv | 19 +
 rtl/lpf_iq_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/lpf_iq_ctrl_if.sv
// lpf_iq_ctrl_if: mixer I/Q sample stream offered to the LPF sequencer.
interface lpf_iq_ctrl_if #(
   parameter int IN_W = 26
);
   logic                   in_valid;
   logic                   in_ready;
   logic signed [IN_W-1:0] in_i;
   logic signed [IN_W-1:0] in_q;

   modport master (
      output in_valid, in_i, in_q,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_i, in_q,
      output in_ready
   );
endinterface

// File: rtl/lpf_iq_ctrl.sv
// lpf_iq_ctrl: sample sequencer for the I/Q Costas-loop low-pass filters.
// Feeds both delay lines, then decimates and scales the filter results.
module lpf_iq_ctrl #(
   parameter int TAPS  = 43,
   parameter int IN_W  = 26,
   parameter int RES_W = 32,
   parameter int DECIM = 4,
   parameter int SHIFT = 8,
   parameter int OUT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    flush,
   lpf_iq_ctrl_if.slave            mix,
   output logic                    lpf_push,
   output logic signed [IN_W-1:0]  lpf_data_i,
   output logic signed [IN_W-1:0]  lpf_data_q,
   input  logic signed [RES_W-1:0] lpf_out_i,
   input  logic signed [RES_W-1:0] lpf_out_q,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] out_i,
   output logic signed [OUT_W-1:0] out_q,
   output logic                    settled,
   output logic                    sat_flag
);

   localparam int CW = $clog2(TAPS + 1);
   localparam logic [CW-1:0] FULL = CW'(TAPS);
   localparam logic [CW-1:0] LAST = CW'(TAPS - 1);
   localparam logic [7:0] DLAST = 8'(DECIM - 1);
   localparam logic signed [RES_W-1:0] HI = RES_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [RES_W-1:0] LO = -HI - 1;

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t         state, nxt;
   logic [CW-1:0]  fill_cnt, fl_cnt;
   logic [7:0]     dcnt;
   logic           cap;
   logic           flushing, full, accept;
   logic           real_push, emit, pick;
   logic [OUT_W:0] res_i, res_q;

   // MSB of the result flags a clipped value
   function automatic logic [OUT_W:0] scale(
      input logic signed [RES_W-1:0] v
   );
      logic signed [RES_W-1:0] s;
      s = v >>> SHIFT;
      if (s > HI)
         scale = {1'b1, HI[OUT_W-1:0]};
      else if (s < LO)
         scale = {1'b1, LO[OUT_W-1:0]};
      else
         scale = {1'b0, s[OUT_W-1:0]};
   endfunction

   assign flushing  = state == FLUSH;
   assign full      = fill_cnt == FULL;
   assign settled   = full;
   assign mix.in_ready =
      (state == FILL || state == RUN) && !flush;
   assign accept    = mix.in_valid && mix.in_ready;
   assign real_push = lpf_push && !flushing;
   assign emit      = cap && !flush && !flushing;
   assign pick      = emit && dcnt == 8'd0;
   assign res_i     = scale(lpf_out_i);
   assign res_q     = scale(lpf_out_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:
            if (enable) nxt = FILL;
         FILL:
            if (!enable) nxt = IDLE;
            else if (full) nxt = RUN;
         RUN:
            if (!enable) nxt = IDLE;
         FLUSH:
            if (fl_cnt == LAST)
               nxt = enable ? FILL : IDLE;
         default:
            nxt = IDLE;
      endcase
      if (flush) nxt = FLUSH;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lpf_push   <= 1'b0;
         lpf_data_i <= '0;
         lpf_data_q <= '0;
         fl_cnt     <= '0;
         fill_cnt   <= '0;
         cap        <= 1'b0;
         dcnt       <= '0;
         out_valid  <= 1'b0;
         out_i      <= '0;
         out_q      <= '0;
         sat_flag   <= 1'b0;
      end else begin
         lpf_push <= accept || nxt == FLUSH;
         if (accept) begin
            lpf_data_i <= mix.in_i;
            lpf_data_q <= mix.in_q;
         end else if (nxt == FLUSH) begin
            lpf_data_i <= '0;
            lpf_data_q <= '0;
         end
         fl_cnt <= (flushing && !flush) ? fl_cnt + 1'b1 : '0;
         // only results of pushes made on a full line qualify
         cap       <= real_push && full;
         out_valid <= pick;
         if (pick) begin
            out_i <= res_i[OUT_W-1:0];
            out_q <= res_q[OUT_W-1:0];
         end
         if (flush || flushing) begin
            fill_cnt <= '0;
            dcnt     <= '0;
            sat_flag <= 1'b0;
         end else begin
            if (real_push && !full)
               fill_cnt <= fill_cnt + 1'b1;
            if (emit)
               dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
            if (pick && (res_i[OUT_W] || res_q[OUT_W]))
               sat_flag <= 1'b1;
         end
      end
   end

endmodule
